dflow_pkt_builder: RTL

- Downstream consumer of the dflow generator's tuple output. Turns each (5-tuple, pkt_len) pair into a complete Ethernet/IPv4/L4 frame on an AXI4-Stream master.
- Single clock domain: the generator's output-side clk. Feeds the MAC/TX path.
- Fills in the IPv4 header checksum and a per-packet IP ID, and pads the payload with a deterministic byte pattern so the receiver can check it.

---
 rtl/dflow_pkt_builder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dflow_pkt_builder.sv
// Builds one Ethernet/IPv4/L4 frame per accepted (5-tuple, length) pair on a 64-bit AXI4-Stream master.
// First beat 2 cycles after accept; beats stall in place while m_axis_tready is low; no tuple accepted outside IDLE.
module dflow_pkt_builder #(
    parameter int          C_M_AXIS_DATA_WIDTH = 64,
    parameter int          PKT_TUPLE_WIDTH     = 104,
    parameter int          PKT_LEN_WIDTH       = 16,
    parameter int          MIN_PKT_LEN         = 60,
    parameter int          MAX_PKT_LEN         = 1514,
    parameter logic [47:0] DST_MAC             = 48'h00_0A_35_00_00_02,
    parameter logic [47:0] SRC_MAC             = 48'h00_0A_35_00_00_01
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [PKT_TUPLE_WIDTH-1:0]       tuple_in_fivetuple_DATA,
    input  logic [PKT_LEN_WIDTH-1:0]         tuple_in_pkt_len,
    input  logic                             tuple_in_VALID,
    output logic                             tuple_in_ready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [31:0]                      pkt_cnt
);
    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  proto;
    } tuple_t;

    typedef enum logic [1:0] {IDLE, CSUM, SEND} state_t;

    localparam logic [PKT_LEN_WIDTH-1:0] MIN_L = PKT_LEN_WIDTH'(MIN_PKT_LEN);
    localparam logic [PKT_LEN_WIDTH-1:0] MAX_L = PKT_LEN_WIDTH'(MAX_PKT_LEN);

    // Assert asynchronously, release two clocks after resetn rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t                   state_q, state_d;
    tuple_t                   tuple_q;
    logic [PKT_LEN_WIDTH-1:0] len_q, len_clamp;
    logic [15:0]              csum_q, csum_d, ip_id_q, tot_len, l4_len;
    logic [7:0]               beat_q, last_beat;
    logic [31:0]              pkt_cnt_q;
    logic                     accept, csum_ld, beat_inc, frame_done, last_c;

    always_comb begin
        len_clamp = tuple_in_pkt_len;
        if (tuple_in_pkt_len < MIN_L)      len_clamp = MIN_L;
        else if (tuple_in_pkt_len > MAX_L) len_clamp = MAX_L;
    end

    assign tot_len   = 16'(len_q) - 16'd14;
    assign l4_len    = 16'(len_q) - 16'd34;
    assign last_beat = 8'((16'(len_q) - 16'd1) >> 3);
    assign last_c    = (beat_q == last_beat);

    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    always_comb begin
        sum = 20'h04500 + 20'(tot_len) + 20'(ip_id_q) + 20'h04000
            + 20'({8'h40, tuple_q.proto})
            + 20'(tuple_q.src_ip[31:16]) + 20'(tuple_q.src_ip[15:0])
            + 20'(tuple_q.dst_ip[31:16]) + 20'(tuple_q.dst_ip[15:0]);
        fold1  = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        fold2  = fold1[15:0] + {15'd0, fold1[16]};
        csum_d = ~fold2;
    end

    always_comb begin
        state_d        = state_q;
        tuple_in_ready = 1'b0;
        accept         = 1'b0;
        csum_ld        = 1'b0;
        beat_inc       = 1'b0;
        frame_done     = 1'b0;
        case (state_q)
            IDLE: begin
                tuple_in_ready = rst_n;
                if (tuple_in_VALID && rst_n) begin
                    accept  = 1'b1;
                    state_d = CSUM;
                end
            end
            CSUM: begin
                csum_ld = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (last_c) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        beat_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tuple_q   <= '0;
            len_q     <= '0;
            csum_q    <= '0;
            beat_q    <= '0;
            ip_id_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tuple_q <= tuple_in_fivetuple_DATA;
                len_q   <= len_clamp;
            end
            if (csum_ld) begin
                csum_q <= csum_d;
                beat_q <= '0;
            end
            if (beat_inc) beat_q <= beat_q + 8'd1;
            if (frame_done) begin
                beat_q    <= '0;
                ip_id_q   <= ip_id_q + 16'd1;
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
        end
    end

    // Byte 0 of the frame sits at index 41 so the header reads in wire order.
    logic [41:0][7:0] hdr;
    assign hdr = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, tot_len, ip_id_q,
                  16'h4000, 8'h40, tuple_q.proto, csum_q,
                  tuple_q.src_ip, tuple_q.dst_ip, tuple_q.src_port, tuple_q.dst_port,
                  l4_len, 16'h0000};

    logic [7:0][7:0] beat_c;
    logic [7:0]      keep_c;
    logic [15:0]     off;
    always_comb begin
        beat_c = '0;
        keep_c = '0;
        off    = '0;
        for (int n = 0; n < 8; n++) begin
            off = {5'd0, beat_q, 3'b000} + 16'(n);
            if (off < 16'(len_q)) begin
                keep_c[n] = 1'b1;
                beat_c[n] = (off < 16'd42) ? hdr[6'd41 - off[5:0]] : off[7:0];
            end
        end
    end

    assign m_axis_tvalid = (state_q == SEND);
    assign m_axis_tdata  = m_axis_tvalid ? beat_c : '0;
    assign m_axis_tkeep  = m_axis_tvalid ? keep_c : '0;
    assign m_axis_tlast  = m_axis_tvalid && last_c;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
